vga_console_master: RTL and testbench
=====================================

// Module: vga_console_master
// PURPOSE
//  Bus initiator that drives the VGA text-mode display slave over the stb/cyc/sel/we/ack bus.
//  Accepts a byte stream of characters and handles printable output, CR, LF, BS and FF.
//  Generates all text-memory writes, screen-scroll copies (read+write) and cursor-register updates.
//  Sits between the CPU-side console FIFO and the VGA device port, on the bus clock.
// PARAMETERS
//  COLS        80            characters per row (1..255)
//  ROWS        60            rows per screen (2..255); ROWS*COLS <= 8192
//  TEXT_BASE   32'h0000_0000 byte address of text cell (0,0)
//  CUR_EN_ADR  32'h0000_2000 byte address of cursor-enable register
//  CUR_ROW_ADR 32'h0000_2001 byte address of cursor-row register
//  CUR_COL_ADR 32'h0000_2002 byte address of cursor-column register
// PORTS
//  clk_i        in   1   bus clock; single clock domain
//  reset_i      in   1   asynchronous, active-low reset
//  char_valid_i in   1   input byte valid
//  char_data_i  in   8   input byte (ASCII)
//  char_ready_o out  1   block accepts byte when valid&ready at rising edge
//  busy_o       out  1   high whenever FSM is not IDLE
//  cyc_o/stb_o  out  1   bus cycle/strobe (always equal)
//  we_o         out  1   1 = write, 0 = read
//  sel_o        out  4   one-hot byte lane = 1<<adr[1:0]
//  adr_o        out  32  {byte_addr[31:2],2'b00}
//  data_o       out  32  write byte replicated on all four lanes
//  data_i       in   32  read data; byte taken from lane selected by sel_o
//  ack_i        in   1   slave acknowledge
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values: cyc/stb/we=0, sel=0, adr=0, data_o=0, char_ready_o=0, busy_o=1; row=col=0; FSM=INIT_CLR.
//  Bus rule: drive cyc/stb/we/sel/adr/data_o together; hold all stable until ack_i=1 at a rising edge;
//   deassert cyc/stb the next cycle; >=1 idle cycle between transactions. No timeout; waits indefinitely.
//   Read data captured on the ack edge.
//  FSM states:
//   INIT_CLR: write 0x20 to all ROWS*COLS cells, ascending from TEXT_BASE.
//   INIT_EN:  write 0x01 to CUR_EN_ADR.
//   CUR_ROW:  write row to CUR_ROW_ADR.
//   CUR_COL:  write col to CUR_COL_ADR; then -> IDLE.
//   IDLE:     char_ready_o=1, busy_o=0; on valid&ready latch byte -> DECODE (ready drops next cycle).
//   DECODE:   one cycle, no bus activity; dispatch by byte value:
//    0x20..0x7E -> WR_CHAR: write byte at TEXT_BASE+row*COLS+col; col++;
//     if col reaches COLS: col=0, newline.
//    0x0A LF    -> col=0; newline.
//    0x0D CR    -> col=0 -> CUR_ROW.
//    0x08 BS    -> if col>0: col--, write 0x20 at new cell, then cursor update; col==0: no write -> CUR_ROW.
//    0x0C FF    -> row=col=0; clear screen (as INIT_CLR) -> CUR_ROW (INIT_EN skipped).
//    other      -> dropped; -> IDLE with no bus traffic.
//   newline: if row<ROWS-1: row++ -> CUR_ROW; else SCROLL.
//   SCROLL: for i=0..COLS*(ROWS-1)-1: read cell i+COLS, write it to cell i (SCR_RD then SCR_WR);
//    then CLR_ROW writes 0x20 to last-row cells; row stays ROWS-1 -> CUR_ROW.
//  Every accepted printable/LF/CR/BS/FF ends with CUR_ROW then CUR_COL (row before col), then IDLE.
//  Address arithmetic: cell index 13 bits, unsigned; byte_addr = TEXT_BASE + index (32-bit, no wrap check).
//  Reset mid-operation: bus signals drop immediately (async); partial scroll abandoned; restart at INIT_CLR.
//  ack_i while cyc_o=0 is ignored.
// TESTING
//  T1 reset release -> ROWS*COLS writes data byte 0x20 (adr 0..4799 byte-wise), then 0x01 to 0x2000, 0x00 to 0x2001, 0x00 to 0x2002; busy_o falls.
//  T2 send 'A'(0x41) at (0,0) -> write adr=0,sel=0001,data_o=32'h41414141; cursor writes row=0, col=1.
//  T3 79 chars then 'B' -> 'B' at byte 79 (adr 0x4C, sel 1000); cursor row=1, col=0.
//  T4 row=59, LF -> 4720 read/write pairs (read 80 -> write 0, ...), 80 writes of 0x20 at 4720..4799; cursor row=59, col=0.
//  T5 ack_i held low 20 cycles during WR_CHAR -> all bus outputs stable; single write completes on ack.
//  T6 BS at col=0 -> only cursor writes (row, col=0); reset_i low mid-scroll -> cyc_o=0 same cycle, INIT_CLR restarts.

Source files
------------

// File: rtl/vga_console_master_if.sv
// Bus bundle between the console master and the VGA text-mode slave.
// cyc/stb/we/sel/adr/data_o come from the master; data_i/ack_i from the slave.
interface vga_console_master_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        ack_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, data_o,
        input  data_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, data_o,
        output data_i, ack_i
    );
endinterface

// File: rtl/vga_console_master.sv
// Console master: turns a byte stream into VGA text-memory writes,
// screen-scroll copies and cursor-register updates.
module vga_console_master #(
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 60,
    parameter logic [31:0] TEXT_BASE   = 32'h0000_0000,
    parameter logic [31:0] CUR_EN_ADR  = 32'h0000_2000,
    parameter logic [31:0] CUR_ROW_ADR = 32'h0000_2001,
    parameter logic [31:0] CUR_COL_ADR = 32'h0000_2002
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        char_valid_i,
    input  logic [7:0]                  char_data_i,
    output logic                        char_ready_o,
    output logic                        busy_o,
    vga_console_master_if.master        vga_bus
);

    localparam logic [12:0] COLS_C         = 13'(COLS);
    localparam logic [12:0] LAST_CELL      = 13'(ROWS * COLS - 1);
    localparam logic [12:0] SCR_LAST       = 13'(COLS * (ROWS - 1) - 1);
    localparam logic [12:0] LAST_ROW_FIRST = 13'(COLS * (ROWS - 1));
    localparam logic [7:0]  LAST_COL       = 8'(COLS - 1);
    localparam logic [7:0]  LAST_ROW       = 8'(ROWS - 1);

    typedef enum logic [3:0] {
        INIT_CLR,
        INIT_EN,
        CUR_ROW,
        CUR_COL,
        IDLE,
        DECODE,
        WR_CHAR,
        BS_WR,
        SCR_RD,
        SCR_WR,
        CLR_ROW
    } state_t;

    state_t      state_q;
    logic [7:0]  row_q;
    logic [7:0]  col_q;
    logic [12:0] idx_q;
    logic [7:0]  char_q;
    logic [7:0]  rd_byte_q;
    logic        init_q;
    logic        cyc_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;

    logic [12:0] cell_idx;
    logic [31:0] tx_adr_d;
    logic [7:0]  tx_byte_d;
    logic        tx_we_d;
    logic [7:0]  lane_byte;

    assign vga_bus.cyc_o  = cyc_q;
    assign vga_bus.stb_o  = cyc_q;
    assign vga_bus.we_o   = we_q;
    assign vga_bus.sel_o  = sel_q;
    assign vga_bus.adr_o  = adr_q;
    assign vga_bus.data_o = dat_q;

    assign char_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);

    // Transaction contents for the bus state currently being serviced.
    always_comb begin
        cell_idx  = 13'(row_q) * COLS_C + {5'b0, col_q};
        tx_we_d   = 1'b1;
        tx_byte_d = 8'h20;
        tx_adr_d  = TEXT_BASE + {19'b0, idx_q};
        case (state_q)
            INIT_EN: begin
                tx_adr_d  = CUR_EN_ADR;
                tx_byte_d = 8'h01;
            end
            CUR_ROW: begin
                tx_adr_d  = CUR_ROW_ADR;
                tx_byte_d = row_q;
            end
            CUR_COL: begin
                tx_adr_d  = CUR_COL_ADR;
                tx_byte_d = col_q;
            end
            WR_CHAR: begin
                tx_adr_d  = TEXT_BASE + {19'b0, cell_idx};
                tx_byte_d = char_q;
            end
            BS_WR: begin
                tx_adr_d  = TEXT_BASE + {19'b0, cell_idx};
            end
            SCR_RD: begin
                tx_adr_d  = TEXT_BASE + {19'b0, idx_q + COLS_C};
                tx_we_d   = 1'b0;
            end
            SCR_WR: begin
                tx_byte_d = rd_byte_q;
            end
            default: ;
        endcase
    end

    // Pick the read byte out of the lane the outstanding read selected.
    always_comb begin
        case (sel_q)
            4'b0010: lane_byte = vga_bus.data_i[15:8];
            4'b0100: lane_byte = vga_bus.data_i[23:16];
            4'b1000: lane_byte = vga_bus.data_i[31:24];
            default: lane_byte = vga_bus.data_i[7:0];
        endcase
    end

    // Control FSM plus bus driver: a bus state issues its transaction when
    // cyc is low, and advances on ack; dropping cyc on the ack edge gives the
    // mandatory idle cycle before the next state's transaction starts.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= INIT_CLR;
            row_q     <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            char_q    <= '0;
            rd_byte_q <= '0;
            init_q    <= 1'b1;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (char_valid_i) begin
                        char_q  <= char_data_i;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (char_q >= 8'h20 && char_q <= 8'h7E) begin
                        state_q <= WR_CHAR;
                    end else begin
                        case (char_q)
                            8'h0A: begin
                                col_q <= '0;
                                if (row_q != LAST_ROW) begin
                                    row_q   <= row_q + 8'd1;
                                    state_q <= CUR_ROW;
                                end else begin
                                    idx_q   <= '0;
                                    state_q <= SCR_RD;
                                end
                            end
                            8'h0D: begin
                                col_q   <= '0;
                                state_q <= CUR_ROW;
                            end
                            8'h08: begin
                                if (col_q != 8'd0) begin
                                    col_q   <= col_q - 8'd1;
                                    state_q <= BS_WR;
                                end else begin
                                    state_q <= CUR_ROW;
                                end
                            end
                            8'h0C: begin
                                row_q   <= '0;
                                col_q   <= '0;
                                idx_q   <= '0;
                                init_q  <= 1'b0;
                                state_q <= INIT_CLR;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                default: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= tx_we_d;
                        adr_q <= {tx_adr_d[31:2], 2'b00};
                        sel_q <= 4'b0001 << tx_adr_d[1:0];
                        dat_q <= {4{tx_byte_d}};
                    end else if (vga_bus.ack_i) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        case (state_q)
                            INIT_CLR: begin
                                if (idx_q == LAST_CELL) begin
                                    idx_q   <= '0;
                                    init_q  <= 1'b0;
                                    state_q <= init_q ? INIT_EN : CUR_ROW;
                                end else begin
                                    idx_q <= idx_q + 13'd1;
                                end
                            end
                            INIT_EN: state_q <= CUR_ROW;
                            CUR_ROW: state_q <= CUR_COL;
                            CUR_COL: state_q <= IDLE;
                            WR_CHAR: begin
                                if (col_q == LAST_COL) begin
                                    col_q <= '0;
                                    if (row_q != LAST_ROW) begin
                                        row_q   <= row_q + 8'd1;
                                        state_q <= CUR_ROW;
                                    end else begin
                                        idx_q   <= '0;
                                        state_q <= SCR_RD;
                                    end
                                end else begin
                                    col_q   <= col_q + 8'd1;
                                    state_q <= CUR_ROW;
                                end
                            end
                            BS_WR: state_q <= CUR_ROW;
                            SCR_RD: begin
                                rd_byte_q <= lane_byte;
                                state_q   <= SCR_WR;
                            end
                            SCR_WR: begin
                                if (idx_q == SCR_LAST) begin
                                    idx_q   <= LAST_ROW_FIRST;
                                    state_q <= CLR_ROW;
                                end else begin
                                    idx_q   <= idx_q + 13'd1;
                                    state_q <= SCR_RD;
                                end
                            end
                            CLR_ROW: begin
                                if (idx_q == LAST_CELL) begin
                                    idx_q   <= '0;
                                    state_q <= CUR_ROW;
                                end else begin
                                    idx_q <= idx_q + 13'd1;
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console_master.sv
// Scoreboard bench for vga_console_master: expected bus transactions are
// queued by the stimulus; a negedge monitor pops and compares each one as
// the slave model acknowledges it.
`timescale 1ns/1ps
module tb_vga_console_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       busy;

    always #5 clk = ~clk;

    vga_console_master_if vga_bus();

    vga_console_master #(
        .COLS(80),
        .ROWS(60),
        .TEXT_BASE(32'h0000_0000),
        .CUR_EN_ADR(32'h0000_2000),
        .CUR_ROW_ADR(32'h0000_2001),
        .CUR_COL_ADR(32'h0000_2002)
    ) dut (
        .clk_i(clk),
        .reset_i(rst_n),
        .char_valid_i(char_valid),
        .char_data_i(char_data),
        .char_ready_o(char_ready),
        .busy_o(busy),
        .vga_bus(vga_bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } txn_t;

    txn_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // Slave model: byte memory, optional ack stall, read lane placement.
    logic [7:0]  mem [0:16383];
    int unsigned stall_cfg = 0;
    int unsigned hold_cnt = 0;
    logic [1:0]  lane;
    logic [13:0] baddr;

    always @(posedge clk) begin
        if (!vga_bus.cyc_o) hold_cnt <= stall_cfg;
        else if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
    end

    assign vga_bus.ack_i = vga_bus.cyc_o && vga_bus.stb_o && (hold_cnt == 0);

    always_comb begin
        lane = 2'd0;
        for (int i = 0; i < 4; i++) if (vga_bus.sel_o[i]) lane = 2'(i);
        baddr = {vga_bus.adr_o[13:2], lane};
        vga_bus.data_i = {4{8'hEE}};
        vga_bus.data_i[int'(lane) * 8 +: 8] = mem[baddr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a transaction completes at the posedge following a negedge
    // that sees cyc & ack.
    always @(negedge clk) begin
        if (rst_n && vga_bus.cyc_o && vga_bus.ack_i) begin
            txn_t e;
            if (vga_bus.we_o) mem[baddr] = vga_bus.data_o[int'(lane) * 8 +: 8];
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_txn: got we=%b adr=%h sel=%b data=%h expected none",
                         vga_bus.we_o, vga_bus.adr_o, vga_bus.sel_o, vga_bus.data_o);
            end else begin
                e = expq.pop_front();
                check("txn_we", {31'b0, vga_bus.we_o}, {31'b0, e.we});
                check("txn_adr", vga_bus.adr_o, e.adr);
                check("txn_sel", {28'b0, vga_bus.sel_o}, {28'b0, e.sel});
                if (e.we) check("txn_data", vga_bus.data_o, e.dat);
            end
        end
    end

    task automatic push_raw(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        txn_t e;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat;
        expq.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] badr, input logic [7:0] b);
        push_raw(1'b1, {badr[31:2], 2'b00}, 4'b0001 << badr[1:0], {4{b}});
    endtask

    task automatic push_r(input logic [31:0] badr);
        push_raw(1'b0, {badr[31:2], 2'b00}, 4'b0001 << badr[1:0], 32'h0);
    endtask

    task automatic push_cursor(input logic [7:0] r, input logic [7:0] c);
        push_w(32'h2001, r);
        push_w(32'h2002, c);
    endtask

    task automatic push_clear_all();
        for (int i = 0; i < 4800; i++) push_w(32'(i), 8'h20);
    endtask

    task automatic push_scroll(input logic use_pat);
        for (int i = 0; i < 4720; i++) begin
            push_r(32'(i + 80));
            push_w(32'(i), use_pat ? pat(i + 80) : 8'h20);
        end
        for (int i = 4720; i < 4800; i++) push_w(32'(i), 8'h20);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) % 251);
    endfunction

    task automatic send_char(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!char_ready && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", {31'b0, char_ready}, 32'd1);
        char_valid = 1'b1;
        char_data  = b;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60000);
        check({nm, "_busy_low"}, {31'b0, busy}, 32'd0);
        check({nm, "_queue_drained"}, expq.size(), 32'd0);
    endtask

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [31:0] s_adr, s_dat;
        logic [3:0]  s_sel;
        logic        s_we, stable;
        int          n;

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_cyc", {31'b0, vga_bus.cyc_o}, 32'd0);
        check("rst_stb", {31'b0, vga_bus.stb_o}, 32'd0);
        check("rst_we", {31'b0, vga_bus.we_o}, 32'd0);
        check("rst_sel", {28'b0, vga_bus.sel_o}, 32'd0);
        check("rst_adr", vga_bus.adr_o, 32'd0);
        check("rst_data", vga_bus.data_o, 32'd0);
        check("rst_ready", {31'b0, char_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);

        // T1: clear screen, enable cursor, home cursor
        push_clear_all();
        push_raw(1'b1, 32'h2000, 4'b0001, 32'h0101_0101);
        push_raw(1'b1, 32'h2000, 4'b0010, 32'h0000_0000);
        push_raw(1'b1, 32'h2000, 4'b0100, 32'h0000_0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t1_init");
        check("t1_ready", {31'b0, char_ready}, 32'd1);

        // T2: 'A' at (0,0)
        push_raw(1'b1, 32'h0, 4'b0001, 32'h4141_4141);
        push_cursor(8'd0, 8'd1);
        send_char(8'h41);
        wait_idle("t2_char");

        // T3: fill row 0, 'B' lands in column 79 and wraps the cursor
        for (int c = 1; c < 79; c++) begin
            push_w(32'(c), 8'(8'h61 + c % 26));
            push_cursor(8'd0, 8'(c + 1));
        end
        push_raw(1'b1, 32'h4C, 4'b1000, 32'h4242_4242);
        push_cursor(8'd1, 8'd0);
        for (int c = 1; c < 79; c++) send_char(8'(8'h61 + c % 26));
        send_char(8'h42);
        wait_idle("t3_wrap");

        // Unsupported control byte: no bus traffic
        send_char(8'h07);
        wait_idle("drop_bel");

        // T6a: BS at column 0 only rewrites the cursor
        push_cursor(8'd1, 8'd0);
        send_char(8'h08);
        wait_idle("t6_bs_col0");

        // 'C' then BS erases it
        push_raw(1'b1, 32'h50, 4'b0001, 32'h4343_4343);
        push_cursor(8'd1, 8'd1);
        push_raw(1'b1, 32'h50, 4'b0001, 32'h2020_2020);
        push_cursor(8'd1, 8'd0);
        send_char(8'h43);
        send_char(8'h08);
        wait_idle("bs_erase");

        // 'D' then CR
        push_raw(1'b1, 32'h50, 4'b0001, 32'h4444_4444);
        push_cursor(8'd1, 8'd1);
        push_cursor(8'd1, 8'd0);
        send_char(8'h44);
        send_char(8'h0D);
        wait_idle("cr");

        // T5: slave stalls the character write for 20 cycles
        stall_cfg = 20;
        push_raw(1'b1, 32'h50, 4'b0001, 32'h4545_4545);
        push_cursor(8'd1, 8'd1);
        send_char(8'h45);
        n = 0;
        while (!vga_bus.cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_cyc_seen", {31'b0, vga_bus.cyc_o}, 32'd1);
        s_we = vga_bus.we_o; s_adr = vga_bus.adr_o; s_sel = vga_bus.sel_o; s_dat = vga_bus.data_o;
        stable = 1'b1;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (!vga_bus.cyc_o || !vga_bus.stb_o || vga_bus.ack_i || vga_bus.we_o !== s_we ||
                vga_bus.adr_o !== s_adr || vga_bus.sel_o !== s_sel || vga_bus.data_o !== s_dat)
                stable = 1'b0;
        end
        check("t5_stall_stable", {31'b0, stable}, 32'd1);
        stall_cfg = 0;
        wait_idle("t5_stall");

        // LF down to the last row
        push_cursor(8'd2, 8'd0);
        for (int r = 3; r < 60; r++) push_cursor(8'(r), 8'd0);
        for (int r = 2; r < 60; r++) send_char(8'h0A);
        wait_idle("lf_to_bottom");

        // T4: LF on the last row scrolls the screen up
        for (int i = 0; i < 4800; i++) mem[i] = pat(i);
        push_scroll(1'b1);
        push_cursor(8'd59, 8'd0);
        send_char(8'h0A);
        wait_idle("t4_scroll");

        // FF: clear and home, cursor enable not rewritten
        push_clear_all();
        push_cursor(8'd0, 8'd0);
        send_char(8'h0C);
        wait_idle("ff_clear");

        // T6b: reset in the middle of a scroll
        for (int r = 1; r < 60; r++) push_cursor(8'(r), 8'd0);
        for (int r = 1; r < 60; r++) send_char(8'h0A);
        wait_idle("lf_to_bottom2");
        push_scroll(1'b0);
        send_char(8'h0A);
        repeat (200) @(negedge clk);
        n = 0;
        while (!vga_bus.cyc_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_scroll_active", {31'b0, vga_bus.cyc_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", {31'b0, vga_bus.cyc_o}, 32'd0);
        check("t6_rst_stb", {31'b0, vga_bus.stb_o}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd1);
        expq.delete();
        push_clear_all();
        push_raw(1'b1, 32'h2000, 4'b0001, 32'h0101_0101);
        push_cursor(8'd0, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t6_reinit");
        check("t6_ready", {31'b0, char_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
